vga_sync_gen: RTL and testbench

//   Pixel-timing source and output stage for the VGA path. Free-running h/v counters

---
 rtl/vga_sync_gen_pkg.sv | 43 ++++
 rtl/sig_delay_line.sv | 41 ++++
 rtl/vga_sync_gen.sv | 151 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_pkg
// Description : Shared VGA timing sets (640x480@60 default, 800x600@60) and
//               small helpers used by the sync generator and display stages.
// Contents    : VGA640_* / VGA800_* timing localparams, CNT_W counter width,
//               sync_level() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_sync_gen_pkg;

  // Counter width shared by h_cnt, v_cnt and the geometry ports.
  localparam int CNT_W = 11;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative sync polarity.
  localparam int   VGA640_H_VISIBLE     = 640;
  localparam int   VGA640_H_FRONT_PORCH = 16;
  localparam int   VGA640_H_SYNC        = 96;
  localparam int   VGA640_H_BACK_PORCH  = 48;
  localparam int   VGA640_V_VISIBLE     = 480;
  localparam int   VGA640_V_FRONT_PORCH = 10;
  localparam int   VGA640_V_SYNC        = 2;
  localparam int   VGA640_V_BACK_PORCH  = 33;
  localparam logic VGA640_SYNC_ACTIVE   = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive sync polarity.
  localparam int   VGA800_H_VISIBLE     = 800;
  localparam int   VGA800_H_FRONT_PORCH = 40;
  localparam int   VGA800_H_SYNC        = 128;
  localparam int   VGA800_H_BACK_PORCH  = 88;
  localparam int   VGA800_V_VISIBLE     = 600;
  localparam int   VGA800_V_FRONT_PORCH = 1;
  localparam int   VGA800_V_SYNC        = 4;
  localparam int   VGA800_V_BACK_PORCH  = 23;
  localparam logic VGA800_SYNC_ACTIVE   = 1'b1;

  // Pin level for a sync signal given whether the pulse is asserted.
  function automatic logic sync_level(input logic asserted, input logic active_level);
    return asserted ? active_level : ~active_level;
  endfunction

endpackage : vga_sync_gen_pkg
`default_nettype wire

// File: rtl/sig_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sig_delay_line
// Description : DEPTH-stage shift register, WIDTH bits wide, asynchronously
//               cleared to a per-bit reset value.
// Ports       : clk   in  1      clock
//               rst_n in  1      asynchronous active-low reset
//               d_i   in  WIDTH  input word
//               q_o   out WIDTH  input word delayed DEPTH cycles
// Revision    : 1.0 - initial release
// ============================================================================
module sig_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,   // must be >= 1
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule : sig_delay_line
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA pixel-timing source and pin output stage. Free-running
//               h/v counters feed the display stages; the returned RGB is
//               blanked and registered to the pins with hsync/vsync delayed
//               to match the pixel-fetch latency.
// Ports       : clk, rst_n                 pixel clock, async active-low reset
//               h_cnt, v_cnt       out 11  counters (0..H_TOTAL-1 / V_TOTAL-1)
//               h_visible, h_back_porch,
//               v_visible, v_back_porch out 11  constant geometry
//               frame_start        out 1   high while h_cnt==0 && v_cnt==0
//               i_r, i_g, i_b      in  4   pixel, PIX_LATENCY after counters
//               vga_r, vga_g, vga_b out 4  blanked pixel to pins
//               vga_hs, vga_vs     out 1   sync to pins
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   H_VISIBLE     = VGA640_H_VISIBLE,
  parameter int   H_FRONT_PORCH = VGA640_H_FRONT_PORCH,
  parameter int   H_SYNC        = VGA640_H_SYNC,
  parameter int   H_BACK_PORCH  = VGA640_H_BACK_PORCH,
  parameter int   V_VISIBLE     = VGA640_V_VISIBLE,
  parameter int   V_FRONT_PORCH = VGA640_V_FRONT_PORCH,
  parameter int   V_SYNC        = VGA640_V_SYNC,
  parameter int   V_BACK_PORCH  = VGA640_V_BACK_PORCH,
  parameter logic SYNC_ACTIVE   = VGA640_SYNC_ACTIVE,
  parameter int   PIX_LATENCY   = 2      // legal range 1..8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic [CNT_W-1:0] h_visible,
  output logic [CNT_W-1:0] h_back_porch,
  output logic [CNT_W-1:0] v_visible,
  output logic [CNT_W-1:0] v_back_porch,
  output logic             frame_start,
  input  logic [3:0]       i_r,
  input  logic [3:0]       i_g,
  input  logic [3:0]       i_b,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs
);

  // Line layout from count 0: sync, back porch, visible, front porch.
  // Totals are expected to fit the 11-bit counters (<= 2047).
  localparam logic [CNT_W-1:0] C_H_TOTAL     = CNT_W'(H_SYNC + H_BACK_PORCH + H_VISIBLE + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0] C_V_TOTAL     = CNT_W'(V_SYNC + V_BACK_PORCH + V_VISIBLE + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0] C_H_SYNC      = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] C_V_SYNC      = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] C_H_ACT_START = CNT_W'(H_SYNC + H_BACK_PORCH);
  localparam logic [CNT_W-1:0] C_H_ACT_END   = CNT_W'(H_SYNC + H_BACK_PORCH + H_VISIBLE);
  localparam logic [CNT_W-1:0] C_V_ACT_START = CNT_W'(V_SYNC + V_BACK_PORCH);
  localparam logic [CNT_W-1:0] C_V_ACT_END   = CNT_W'(V_SYNC + V_BACK_PORCH + V_VISIBLE);

  // Delay-line word layout: [2] hsync level, [1] vsync level, [0] active.
  localparam logic [2:0] C_DL_RST = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap;
  logic             raw_hs;
  logic             raw_vs;
  logic             pix_active;
  logic [2:0]       dl_d;
  logic [2:0]       dl_q;
  logic             hs_q;
  logic             vs_q;
  logic [11:0]      rgb_q;

  // --------------------------------------------------------------------------
  // Counters: v advances only on the h wrap cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    h_wrap  = (h_cnt_q == C_H_TOTAL - CNT_W'(1));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == C_V_TOTAL - CNT_W'(1)) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Compare logic on the registered counters.
  // --------------------------------------------------------------------------
  assign raw_hs     = (h_cnt_q < C_H_SYNC);
  assign raw_vs     = (v_cnt_q < C_V_SYNC);
  assign pix_active = (h_cnt_q >= C_H_ACT_START) && (h_cnt_q < C_H_ACT_END) &&
                      (v_cnt_q >= C_V_ACT_START) && (v_cnt_q < C_V_ACT_END);

  assign dl_d = {sync_level(raw_hs, SYNC_ACTIVE), sync_level(raw_vs, SYNC_ACTIVE), pix_active};

  // Matches the BRAM read + display register latency of the pixel path, so
  // the delayed active flag lines up with the returned i_r/g/b.
  sig_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LATENCY),
    .RST_VAL (C_DL_RST)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dl_d),
    .q_o   (dl_q)
  );

  // --------------------------------------------------------------------------
  // Output register: the only thing driving the pins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
      rgb_q <= '0;
    end else begin
      hs_q  <= dl_q[2];
      vs_q  <= dl_q[1];
      rgb_q <= dl_q[0] ? {i_r, i_g, i_b} : 12'h000;
    end
  end

  assign h_cnt        = h_cnt_q;
  assign v_cnt        = v_cnt_q;
  assign frame_start  = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign h_visible    = CNT_W'(H_VISIBLE);
  assign h_back_porch = C_H_ACT_START;
  assign v_visible    = CNT_W'(V_VISIBLE);
  assign v_back_porch = C_V_ACT_START;
  assign vga_hs       = hs_q;
  assign vga_vs       = vs_q;
  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];

endmodule : vga_sync_gen
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen. A default 640x480
//               instance and a tiny-timing instance are compared cycle by
//               cycle against a frame-position model of the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  typedef struct {
    int   hv, hfp, hsy, hbp;
    int   vv, vfp, vsy, vbp;
    logic sa;
    int   pl;
  } tim_t;

  localparam int M_RANDOM = 0;
  localparam int M_ALIGN  = 1;
  localparam int M_WHITE  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst_n;
  logic [3:0]  i_r, i_g, i_b;
  logic [10:0] h_cnt, v_cnt, h_visible, h_back_porch, v_visible, v_back_porch;
  logic        frame_start, vga_hs, vga_vs;
  logic [3:0]  vga_r, vga_g, vga_b;

  // small-timing instance
  logic        s_rst_n;
  logic [3:0]  s_i_r, s_i_g, s_i_b;
  logic [10:0] s_h_cnt, s_v_cnt, s_h_visible, s_h_back_porch, s_v_visible, s_v_back_porch;
  logic        s_frame_start, s_vga_hs, s_vga_vs;
  logic [3:0]  s_vga_r, s_vga_g, s_vga_b;

  vga_sync_gen dut (
    .clk(clk), .rst_n(rst_n),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .h_visible(h_visible), .h_back_porch(h_back_porch),
    .v_visible(v_visible), .v_back_porch(v_back_porch),
    .frame_start(frame_start),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  vga_sync_gen #(
    .H_VISIBLE(4), .H_FRONT_PORCH(1), .H_SYNC(2), .H_BACK_PORCH(1),
    .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .SYNC_ACTIVE(1'b1), .PIX_LATENCY(1)
  ) dut_s (
    .clk(clk), .rst_n(s_rst_n),
    .h_cnt(s_h_cnt), .v_cnt(s_v_cnt),
    .h_visible(s_h_visible), .h_back_porch(s_h_back_porch),
    .v_visible(s_v_visible), .v_back_porch(s_v_back_porch),
    .frame_start(s_frame_start),
    .i_r(s_i_r), .i_g(s_i_g), .i_b(s_i_b),
    .vga_r(s_vga_r), .vga_g(s_vga_g), .vga_b(s_vga_b),
    .vga_hs(s_vga_hs), .vga_vs(s_vga_vs)
  );

  int   errors = 0;
  int   checks = 0;
  int   k;          // clock edges since the default instance left reset
  int   sk;         // same for the small instance
  int   hs_low, vs_low, nz_pix;
  bit   align_seen;
  tim_t TD, TS;

  // --------------------------------------------------------------------------
  // Reference model: where in the frame a linear index lands, and what the
  // pins must show for it. Pins lag the counters by pl+1 edges.
  // --------------------------------------------------------------------------
  function automatic int htot(tim_t t);
    return t.hv + t.hfp + t.hsy + t.hbp;
  endfunction

  function automatic int vtot(tim_t t);
    return t.vv + t.vfp + t.vsy + t.vbp;
  endfunction

  function automatic bit is_active(tim_t t, int idx);
    int h, v;
    h = idx % htot(t);
    v = (idx / htot(t)) % vtot(t);
    return (h >= t.hsy + t.hbp) && (h < t.hsy + t.hbp + t.hv) &&
           (v >= t.vsy + t.vbp) && (v < t.vsy + t.vbp + t.vv);
  endfunction

  // {h_cnt, v_cnt, frame_start, hs, vs, rgb} expected after k edges
  function automatic logic [36:0] exp_vec(tim_t t, int kk, logic [11:0] rgb_in);
    int          ht, vt, idx, h, v;
    logic        fs, hs, vs;
    logic [11:0] px;
    ht  = htot(t);
    vt  = vtot(t);
    fs  = ((kk % (ht * vt)) == 0);
    idx = kk - t.pl - 1;
    if (idx < 0) begin
      hs = ~t.sa;
      vs = ~t.sa;
      px = 12'h000;
    end else begin
      h  = idx % ht;
      v  = (idx / ht) % vt;
      hs = (h < t.hsy) ? t.sa : ~t.sa;
      vs = (v < t.vsy) ? t.sa : ~t.sa;
      px = is_active(t, idx) ? rgb_in : 12'h000;
    end
    return {11'(kk % ht), 11'((kk / ht) % vt), fs, hs, vs, px};
  endfunction

  // --------------------------------------------------------------------------
  // Default-instance helpers
  // --------------------------------------------------------------------------
  task automatic reset_default();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    k      = 0;
    hs_low = 0;
    vs_low = 0;
    nz_pix = 0;
  endtask

  task automatic run_default(input int ncyc, input int mode);
    logic [11:0] cur;
    logic [36:0] act, expv;
    int          idx2;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      cur  = {i_r, i_g, i_b};
      act  = {h_cnt, v_cnt, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b};
      expv = exp_vec(TD, k, cur);
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL scan k=%0d got=%h expected=%h", k, act, expv);
      end
      if (vga_hs == 1'b0) hs_low++;
      if (vga_vs == 1'b0) vs_low++;
      if ({vga_r, vga_g, vga_b} != 12'h000) nz_pix++;
      // first active column of the first active line
      if (mode == M_ALIGN && (k - 3) == 35 * 800 + 144) begin
        align_seen = 1'b1;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h090) begin
          errors++;
          $display("FAIL align_first_col got=%h expected=090", {vga_r, vga_g, vga_b});
        end
      end
      case (mode)
        M_ALIGN: begin
          idx2 = k - 2;
          {i_r, i_g, i_b} = (idx2 >= 0) ? 12'(idx2 % 800) : 12'h000;
        end
        M_WHITE: {i_r, i_g, i_b} = 12'hFFF;
        default: {i_r, i_g, i_b} = 12'($urandom);
      endcase
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [36:0] act, expv;
    rst_n   = 1'b0;
    s_rst_n = 1'b0;
    {i_r, i_g, i_b}       = 12'h000;
    {s_i_r, s_i_g, s_i_b} = 12'h000;
    repeat (3) @(negedge clk);
    act  = {h_cnt, v_cnt, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b};
    expv = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 12'h000};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL reset_state got=%h expected=%h", act, expv);
    end
    act  = {s_h_cnt, s_v_cnt, s_frame_start, s_vga_hs, s_vga_vs, s_vga_r, s_vga_g, s_vga_b};
    expv = {11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 12'h000};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL reset_state_small got=%h expected=%h", act, expv);
    end
  endtask

  task automatic test_geometry();
    checks++;
    if ({h_visible, h_back_porch, v_visible, v_back_porch} !== {11'd640, 11'd144, 11'd480, 11'd35}) begin
      errors++;
      $display("FAIL geometry got=%0d/%0d/%0d/%0d expected=640/144/480/35",
               h_visible, h_back_porch, v_visible, v_back_porch);
    end
    checks++;
    if ({s_h_visible, s_h_back_porch, s_v_visible, s_v_back_porch} !== {11'd4, 11'd3, 11'd3, 11'd2}) begin
      errors++;
      $display("FAIL geometry_small got=%0d/%0d/%0d/%0d expected=4/3/3/2",
               s_h_visible, s_h_back_porch, s_v_visible, s_v_back_porch);
    end
  endtask

  // i_rgb carries the h count from two cycles earlier; 36 lines reach the
  // first visible line.
  task automatic test_alignment();
    @(negedge clk);
    rst_n      = 1'b1;
    k          = 0;
    align_seen = 1'b0;
    run_default(36 * 800, M_ALIGN);
    checks++;
    if (!align_seen) begin
      errors++;
      $display("FAIL align_reached got=0 expected=1");
    end
  endtask

  task automatic test_blanking_sync();
    reset_default();
    run_default(36 * 800, M_WHITE);
    checks++;
    if (vs_low !== 1600) begin
      errors++;
      $display("FAIL vs_low_clks got=%0d expected=1600", vs_low);
    end
    checks++;
    if (hs_low !== 36 * 96) begin
      errors++;
      $display("FAIL hs_low_clks got=%0d expected=%0d", hs_low, 36 * 96);
    end
    checks++;
    if (nz_pix !== 640) begin
      errors++;
      $display("FAIL nonzero_pixels got=%0d expected=640", nz_pix);
    end
  endtask

  // Continues the white scan to h=400 on a visible line, then resets
  // asynchronously between clock edges.
  task automatic test_midframe_reset();
    logic [36:0] act, expv;
    run_default(400, M_WHITE);
    checks++;
    if (h_cnt !== 11'd400 || v_cnt !== 11'd36 || {vga_r, vga_g, vga_b} !== 12'hFFF) begin
      errors++;
      $display("FAIL midframe_pos got=h%0d v%0d rgb%h expected=h400 v36 rgbFFF",
               h_cnt, v_cnt, {vga_r, vga_g, vga_b});
    end
    #2 rst_n = 1'b0;
    #1;
    act  = {h_cnt, v_cnt, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b};
    expv = exp_vec(TD, 0, 12'h000);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL async_reset got=%h expected=%h", act, expv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL restart_frame_start got=%b expected=1", frame_start);
    end
    run_default(1700, M_RANDOM);
  endtask

  task automatic run_small(input int ncyc);
    logic [11:0] cur;
    logic [36:0] act, expv;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      sk++;
      @(negedge clk);
      cur  = {s_i_r, s_i_g, s_i_b};
      act  = {s_h_cnt, s_v_cnt, s_frame_start, s_vga_hs, s_vga_vs, s_vga_r, s_vga_g, s_vga_b};
      expv = exp_vec(TS, sk, cur);
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL small k=%0d got=%h expected=%h", sk, act, expv);
      end
      {s_i_r, s_i_g, s_i_b} = 12'($urandom);
    end
  endtask

  task automatic test_small();
    logic [36:0] act, expv;
    int          fr = 8 * 6;
    @(negedge clk);
    s_rst_n = 1'b1;
    sk      = 0;
    run_small(3 * fr);
    run_small($urandom_range(5, fr - 1));
    #2 s_rst_n = 1'b0;
    #1;
    act  = {s_h_cnt, s_v_cnt, s_frame_start, s_vga_hs, s_vga_vs, s_vga_r, s_vga_g, s_vga_b};
    expv = exp_vec(TS, 0, 12'h000);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL small_async_reset got=%h expected=%h", act, expv);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    s_rst_n = 1'b1;
    sk      = 0;
    run_small(3 * fr);
  endtask

  initial begin
    TD = '{hv: 640, hfp: 16, hsy: 96, hbp: 48, vv: 480, vfp: 10, vsy: 2, vbp: 33, sa: 1'b0, pl: 2};
    TS = '{hv: 4, hfp: 1, hsy: 2, hbp: 1, vv: 3, vfp: 1, vsy: 1, vbp: 1, sa: 1'b1, pl: 1};
    test_reset();
    test_geometry();
    test_small();
    test_alignment();
    test_blanking_sync();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vga_sync_gen
`default_nettype wire
